pipeline_fg_fetch: RTL and testbench

PIPELINE_FG_FETCH -- requirements
Module: pipeline_fg_fetch

---
 rtl/pipeline_fg_fetch.sv | 157 +++++++++++++++
 tb/tb_pipeline_fg_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fg_fetch.sv
// Foreground pixel fetch: fixed-latency SRAM read pipeline plus a 4-entry capture write FIFO.
// Optional build macro FG_FETCH_BOUNDS_CHECK_EN suppresses reads for out-of-frame requests.
module pipeline_fg_fetch #(
    parameter int PIXEL_SIZE                   = 16,
    parameter int PRECISION                    = 11,
    parameter int RESOLUTION_X                 = 800,
    parameter int RESOLUTION_Y                 = 600,
    parameter int ADDR_WIDTH                   = 19,
    parameter int SRAM_READ_LATENCY            = 2,
    parameter int FOREGROUND_FETCH_CYCLE_DELAY = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [PRECISION:0]   fg_pixel_request_x,
    input  logic signed [PRECISION:0]   fg_pixel_request_y,
    input  logic                        fg_pixel_request_active,
    output logic [PIXEL_SIZE-1:0]       fg_pixel_in,
    output logic                        fg_pixel_ready,
    input  logic [PIXEL_SIZE-1:0]       cap_pixel,
    input  logic [PRECISION-1:0]        cap_x,
    input  logic [PRECISION-1:0]        cap_y,
    input  logic                        cap_valid,
    input  logic                        ctrl_fg_freeze,
    output logic                        cap_overflow,
    output logic [ADDR_WIDTH-1:0]       sram_addr,
    output logic                        sram_re,
    output logic                        sram_we,
    output logic [PIXEL_SIZE-1:0]       sram_wdata,
    input  logic [PIXEL_SIZE-1:0]       sram_rdata
);
    // Valid line spans read issue up to the cycle before ready; PAD aligns read data to it.
    localparam int VL  = FOREGROUND_FETCH_CYCLE_DELAY - 1;
    localparam int PAD = FOREGROUND_FETCH_CYCLE_DELAY - SRAM_READ_LATENCY - 2;

    function automatic logic [ADDR_WIDTH-1:0] calc_addr(input logic [ADDR_WIDTH-1:0] x,
                                                        input logic [ADDR_WIDTH-1:0] y);
        return y * ADDR_WIDTH'(RESOLUTION_X) + x;
    endfunction

    logic                  req_fire_s;
    logic                  req_valid_r;
    logic [ADDR_WIDTH-1:0] req_addr_r;
    logic [VL-1:0]         vline_r;
    logic [PIXEL_SIZE-1:0] rdata_aligned_s;

    logic [ADDR_WIDTH-1:0] fifo_addr_r [4];
    logic [PIXEL_SIZE-1:0] fifo_data_r [4];
    logic [1:0]            wr_ptr_r;
    logic [1:0]            rd_ptr_r;
    logic [2:0]            count_r;
    logic                  push_req_s;
    logic                  push_s;
    logic                  pop_s;

`ifdef FG_FETCH_BOUNDS_CHECK_EN
    localparam logic signed [PRECISION:0] RES_X_S = (PRECISION+1)'(RESOLUTION_X);
    localparam logic signed [PRECISION:0] RES_Y_S = (PRECISION+1)'(RESOLUTION_Y);
    assign req_fire_s = fg_pixel_request_active
                        && !fg_pixel_request_x[PRECISION] && (fg_pixel_request_x < RES_X_S)
                        && !fg_pixel_request_y[PRECISION] && (fg_pixel_request_y < RES_Y_S);
`else
    assign req_fire_s = fg_pixel_request_active;
`endif

    // Request register, valid delay line and ready/pixel output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid_r    <= 1'b0;
            req_addr_r     <= '0;
            vline_r        <= '0;
            fg_pixel_ready <= 1'b0;
            fg_pixel_in    <= '0;
        end else begin
            req_valid_r    <= req_fire_s;
            if (req_fire_s) begin
                req_addr_r <= calc_addr(ADDR_WIDTH'(fg_pixel_request_x), ADDR_WIDTH'(fg_pixel_request_y));
            end
            vline_r        <= {vline_r[VL-2:0], req_fire_s};
            fg_pixel_ready <= vline_r[VL-1];
            if (vline_r[VL-1]) begin
                fg_pixel_in <= rdata_aligned_s;
            end
        end
    end

    generate
        if (PAD == 0) begin : g_nopad
            assign rdata_aligned_s = sram_rdata;
        end else begin : g_pad
            logic [PIXEL_SIZE-1:0] pad_r [PAD];
            // Read-data pad pipeline
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PAD; i++) pad_r[i] <= '0;
                end else begin
                    pad_r[0] <= sram_rdata;
                    for (int i = 1; i < PAD; i++) pad_r[i] <= pad_r[i-1];
                end
            end
            assign rdata_aligned_s = pad_r[PAD-1];
        end
    endgenerate

    // Reads own the SRAM port; a write drains only in a read-free cycle.
    assign push_req_s = cap_valid && !ctrl_fg_freeze;
    assign pop_s      = !req_valid_r && (count_r != 3'd0);
    assign push_s     = push_req_s && ((count_r != 3'd4) || pop_s);

    // Capture write FIFO and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_addr_r[i] <= '0;
                fifo_data_r[i] <= '0;
            end
            wr_ptr_r     <= 2'd0;
            rd_ptr_r     <= 2'd0;
            count_r      <= 3'd0;
            cap_overflow <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_r] <= calc_addr(ADDR_WIDTH'(cap_x), ADDR_WIDTH'(cap_y));
                fifo_data_r[wr_ptr_r] <= cap_pixel;
                wr_ptr_r              <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
            if (push_req_s && !push_s) begin
                cap_overflow <= 1'b1;
            end
        end
    end

    assign sram_re = req_valid_r;
    assign sram_we = pop_s;

    // SRAM address/data mux
    always_comb begin
        sram_addr  = '0;
        sram_wdata = '0;
        if (req_valid_r) begin
            sram_addr = req_addr_r;
        end else if (pop_s) begin
            sram_addr  = fifo_addr_r[rd_ptr_r];
            sram_wdata = fifo_data_r[rd_ptr_r];
        end else begin
            sram_addr  = '0;
            sram_wdata = '0;
        end
    end
endmodule

// File: tb/tb_pipeline_fg_fetch.sv
// Directed + randomized bench for pipeline_fg_fetch against a cycle-indexed expectation model
// and a behavioural SRAM / write-queue model.
module tb_pipeline_fg_fetch;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [11:0] req_x = '0;
    logic signed [11:0] req_y = '0;
    logic               req_act = 1'b0;
    logic [15:0]        fg_pixel_in;
    logic               fg_pixel_ready;
    logic [15:0]        cap_pixel = '0;
    logic [10:0]        cap_x = '0;
    logic [10:0]        cap_y = '0;
    logic               cap_valid = 1'b0;
    logic               freeze = 1'b0;
    logic               cap_overflow;
    logic [18:0]        sram_addr;
    logic               sram_re;
    logic               sram_we;
    logic [15:0]        sram_wdata;
    logic [15:0]        sram_rdata = '0;

    pipeline_fg_fetch dut (
        .clk(clk), .rst(rst),
        .fg_pixel_request_x(req_x), .fg_pixel_request_y(req_y),
        .fg_pixel_request_active(req_act),
        .fg_pixel_in(fg_pixel_in), .fg_pixel_ready(fg_pixel_ready),
        .cap_pixel(cap_pixel), .cap_x(cap_x), .cap_y(cap_y), .cap_valid(cap_valid),
        .ctrl_fg_freeze(freeze), .cap_overflow(cap_overflow),
        .sram_addr(sram_addr), .sram_re(sram_re), .sram_we(sram_we),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [18:0] a; logic [15:0] d; } wr_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rdy_cnt = 0;
    int          wr_cnt = 0;
    bit          exp_re  [8192];
    logic [18:0] exp_addr[8192];
    bit          exp_rdy [8192];
    logic [15:0] exp_data[8192];
    logic [15:0] last_pix = '0;
    bit          ovf_m = 1'b0;
    wr_t         fq[$];
    logic [15:0] rq[$];
    logic [15:0] mem [int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] memval(input logic [18:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [18:0] pix_addr(input int x, input int y);
        return 19'((y * 800 + x) & 32'h7FFFF);
    endfunction

    // Per-cycle checker plus behavioural SRAM and write-queue model
    always @(negedge clk) begin
        int   c;
        logic pop_m;
        c = cyc;
        chk("sram_re", sram_re, exp_re[c]);
        chk("re_we_excl", sram_re & sram_we, 1'b0);
        if (exp_re[c]) begin
            chk("rd_addr", sram_addr, exp_addr[c]);
            exp_data[c+4] = memval(exp_addr[c]);
        end
        pop_m = !exp_re[c] && (fq.size() > 0);
        chk("sram_we", sram_we, pop_m);
        if (pop_m) begin
            chk("wr_addr", sram_addr, fq[0].a);
            chk("wr_data", sram_wdata, fq[0].d);
            void'(fq.pop_front());
        end
        if (sram_we) begin
            mem[int'(sram_addr)] = sram_wdata;
            wr_cnt++;
        end
        chk("ready", fg_pixel_ready, exp_rdy[c]);
        if (exp_rdy[c]) last_pix = exp_data[c];
        chk("pixel", fg_pixel_in, last_pix);
        if (fg_pixel_ready) rdy_cnt++;
        chk("overflow", cap_overflow, ovf_m);
        if (!rst && cap_valid && !freeze) begin
            if (fq.size() < 4) fq.push_back('{pix_addr(int'(cap_x), int'(cap_y)), cap_pixel});
            else ovf_m = 1'b1;
        end
        rq.push_back(sram_re ? memval(sram_addr) : 16'($urandom));
        if (rq.size() > 2) sram_rdata = rq.pop_front();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req_act   = 1'b0;
        cap_valid = 1'b0;
        freeze    = 1'b0;
    endtask

    task automatic do_req(input bit act, input int x, input int y);
        bit inr;
        req_act = act;
        req_x   = 12'(x);
        req_y   = 12'(y);
        inr     = 1'b1;
`ifdef FG_FETCH_BOUNDS_CHECK_EN
        inr = (x >= 0) && (x < 800) && (y >= 0) && (y < 600);
`endif
        if (act && inr && !rst) begin
            exp_re[cyc+1]   = 1'b1;
            exp_addr[cyc+1] = pix_addr(x, y);
            exp_rdy[cyc+5]  = 1'b1;
        end
        step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = cyc; i < 8192; i++) begin
            exp_re[i]  = 1'b0;
            exp_rdy[i] = 1'b0;
        end
        fq.delete();
        ovf_m    = 1'b0;
        last_pix = '0;
    endtask

    initial begin
        int n0, r0, w0, rr;
        repeat (3) step();
        chk("rst_re", sram_re, 1'b0);
        chk("rst_ready", fg_pixel_ready, 1'b0);
        chk("rst_pix", fg_pixel_in, 16'h0000);
        chk("rst_ovf", cap_overflow, 1'b0);
        rst = 1'b0;
        step();

        // single fetch (10,2)
        mem[1610] = 16'hABCD;
        n0 = cyc;
        do_req(1'b1, 10, 2);
        set_idle();
        #3;
        chk("s1_re", sram_re, 1'b1);
        chk("s1_addr", sram_addr, 19'd1610);
        repeat (4) step();
        #3;
        chk("s1_cycle", cyc - n0, 32'd5);
        chk("s1_ready", fg_pixel_ready, 1'b1);
        chk("s1_pix", fg_pixel_in, 16'hABCD);
        step();

`ifdef FG_FETCH_BOUNDS_CHECK_EN
        r0 = rdy_cnt;
        do_req(1'b1, -1, 0);
        do_req(1'b1, 800, 0);
        set_idle();
        repeat (7) step();
        chk("oob_ready_cnt", rdy_cnt - r0, 32'd0);
`endif

        // 800 back-to-back requests on row 0
        r0 = rdy_cnt;
        for (int i = 0; i < 800; i++) do_req(1'b1, i, 0);
        set_idle();
        repeat (7) step();
        chk("stream_ready_cnt", rdy_cnt - r0, 32'd800);

        // freeze: captures ignored
        w0 = wr_cnt;
        freeze = 1'b1;
        cap_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cap_x = 11'(i); cap_y = 11'd300; cap_pixel = 16'(i);
            step();
        end
        set_idle();
        repeat (4) step();
        chk("freeze_writes", wr_cnt - w0, 32'd0);

        // overflow under continuous reads
        w0 = wr_cnt;
        chk("ovf_pre", cap_overflow, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cap_valid = 1'b1; cap_x = 11'(100 + i); cap_y = 11'd500; cap_pixel = 16'h1000 + 16'(i);
            do_req(1'b1, i, 1);
        end
        cap_valid = 1'b0;
        for (int i = 0; i < 3; i++) do_req(1'b1, 5 + i, 1);
        set_idle();
        #3;
        chk("ovf_set", cap_overflow, 1'b1);
        chk("ovf_no_write_yet", wr_cnt - w0, 32'd0);
        repeat (8) step();
        chk("ovf_writes", wr_cnt - w0, 32'd4);
        for (int i = 0; i < 4; i++) chk("ovf_mem", memval(pix_addr(100 + i, 500)), 32'h1000 + i);
        chk("ovf_dropped", mem.exists(int'(pix_addr(104, 500))), 1'b0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            rr = int'($urandom_range(0, 9));
            cap_valid = (rr < 4);
            freeze    = ($urandom_range(0, 4) == 0);
            cap_x     = 11'($urandom_range(0, 799));
            cap_y     = 11'($urandom_range(0, 599));
            cap_pixel = 16'($urandom);
            do_req(bit'($urandom_range(0, 1)), int'($urandom_range(0, 799)), int'($urandom_range(0, 599)));
        end
        set_idle();
        repeat (10) step();

        // reset with requests in flight
        for (int i = 0; i < 3; i++) do_req(1'b1, 20 + i, 3);
        set_idle();
        step();
        r0 = rdy_cnt;
        apply_reset();
        #1;
        chk("arst_re", sram_re, 1'b0);
        chk("arst_we", sram_we, 1'b0);
        chk("arst_addr", sram_addr, 19'd0);
        chk("arst_wdata", sram_wdata, 16'h0000);
        chk("arst_ready", fg_pixel_ready, 1'b0);
        chk("arst_pix", fg_pixel_in, 16'h0000);
        chk("arst_ovf", cap_overflow, 1'b0);
        step();
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("arst_no_ready", rdy_cnt - r0, 32'd0);
        do_req(1'b1, 7, 7);
        set_idle();
        repeat (7) step();
        chk("post_rst_ready", rdy_cnt - r0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
